// File: rtl/gs_div_ctrl.sv
// Goldschmidt divider sequencer: steers the multiplier operand muxes and register loads.
// Optional remainder step is enabled by defining GS_DIV_REMAINDER_EN.
//
// state  | meaning
// IDLE   | waiting for start, iter held at 0
// MUL_N  | multiply numerator path, load nNext
// MUL_D  | multiply denominator path, load dNext and kNext
// REM    | remainder multiply quotient*D, load remainder (GS_DIV_REMAINDER_EN only)
// DONE   | one-cycle completion pulse
module gs_div_ctrl #(
  parameter int ITERS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       mux_sel_k,
  output logic [1:0] mux_sel_op,
  output logic       en_n,
  output logic       en_d,
  output logic       en_k,
  output logic [2:0] iter
`ifdef GS_DIV_REMAINDER_EN
  ,
  output logic       rem_mul,
  output logic       en_rem
`endif
);

  localparam logic [2:0] LAST_ITER = 3'(ITERS - 1);

`ifdef GS_DIV_REMAINDER_EN
  typedef enum logic [2:0] {S_IDLE, S_MUL_N, S_MUL_D, S_REM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_MUL_N, S_MUL_D, S_DONE} state_t;
`endif

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_iter;
  logic [2:0] w_iter_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_iter  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_iter  <= w_iter_nxt;
    end
  end

  assign iter = r_iter;

  always_comb begin
    w_state_nxt = r_state;
    w_iter_nxt  = r_iter;
    busy        = 1'b0;
    done        = 1'b0;
    mux_sel_k   = 1'b0;
    mux_sel_op  = 2'b00;
    en_n        = 1'b0;
    en_d        = 1'b0;
    en_k        = 1'b0;
`ifdef GS_DIV_REMAINDER_EN
    rem_mul     = 1'b0;
    en_rem      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_iter_nxt = 3'd0;
        if (start) w_state_nxt = S_MUL_N;
      end
      S_MUL_N: begin
        busy = 1'b1;
        en_n = 1'b1;
        // First pass uses the table seed against raw N; later passes chain nNext.
        if (r_iter == 3'd0) begin
          mux_sel_k  = 1'b1;
          mux_sel_op = 2'b00;
        end else begin
          mux_sel_op = 2'b10;
        end
        if (r_iter < LAST_ITER) begin
          w_state_nxt = S_MUL_D;
        end else begin
`ifdef GS_DIV_REMAINDER_EN
          w_state_nxt = S_REM;
`else
          w_state_nxt = S_DONE;
          w_iter_nxt  = 3'd0;
`endif
        end
      end
      S_MUL_D: begin
        busy = 1'b1;
        en_d = 1'b1;
        en_k = 1'b1;
        if (r_iter == 3'd0) begin
          mux_sel_k  = 1'b1;
          mux_sel_op = 2'b01;
        end else begin
          mux_sel_op = 2'b11;
        end
        w_state_nxt = S_MUL_N;
        w_iter_nxt  = r_iter + 3'd1;
      end
`ifdef GS_DIV_REMAINDER_EN
      S_REM: begin
        busy        = 1'b1;
        rem_mul     = 1'b1;
        en_rem      = 1'b1;
        mux_sel_op  = 2'b01;
        w_state_nxt = S_DONE;
        w_iter_nxt  = 3'd0;
      end
`endif
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
        w_iter_nxt  = 3'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_iter_nxt  = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_gs_div_ctrl.sv
// Scoreboard bench for gs_div_ctrl: ITERS=3 and ITERS=1 instances, macro-aware expectations.
module tb_gs_div_ctrl;

`ifdef GS_DIV_REMAINDER_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       start1 = 1'b0;
  logic       busy, done, mux_sel_k, en_n, en_d, en_k;
  logic [1:0] mux_sel_op;
  logic [2:0] iter;
  logic       busy1, done1, mux_sel_k1, en_n1, en_d1, en_k1;
  logic [1:0] mux_sel_op1;
  logic [2:0] iter1;
  logic       rem_mul, en_rem, rem_mul1, en_rem1;

  int n_cmp = 0;
  int n_err = 0;
  logic [12:0] q3[$];
  logic [12:0] q1[$];

  always #5 clk = ~clk;

  gs_div_ctrl #(.ITERS(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .mux_sel_k(mux_sel_k), .mux_sel_op(mux_sel_op),
    .en_n(en_n), .en_d(en_d), .en_k(en_k), .iter(iter)
`ifdef GS_DIV_REMAINDER_EN
    , .rem_mul(rem_mul), .en_rem(en_rem)
`endif
  );

  gs_div_ctrl #(.ITERS(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .busy(busy1), .done(done1), .mux_sel_k(mux_sel_k1), .mux_sel_op(mux_sel_op1),
    .en_n(en_n1), .en_d(en_d1), .en_k(en_k1), .iter(iter1)
`ifdef GS_DIV_REMAINDER_EN
    , .rem_mul(rem_mul1), .en_rem(en_rem1)
`endif
  );

`ifndef GS_DIV_REMAINDER_EN
  assign rem_mul  = 1'b0;
  assign en_rem   = 1'b0;
  assign rem_mul1 = 1'b0;
  assign en_rem1  = 1'b0;
`endif

  // Vector layout: busy,done,sel_k,op[1:0],en_n,en_d,en_k,iter[2:0],rem_mul,en_rem
  function automatic logic [12:0] ev(bit b, bit d, bit k, logic [1:0] op, bit n, bit dd,
                                     bit kk, logic [2:0] it, bit rm, bit er);
    return {b, d, k, op, n, dd, kk, it, rm, er};
  endfunction

  function automatic logic [12:0] obs3();
    return {busy, done, mux_sel_k, mux_sel_op, en_n, en_d, en_k, iter, rem_mul, en_rem};
  endfunction

  function automatic logic [12:0] obs1();
    return {busy1, done1, mux_sel_k1, mux_sel_op1, en_n1, en_d1, en_k1, iter1, rem_mul1, en_rem1};
  endfunction

  function automatic logic [12:0] v_mul_n(int i);
    return ev(1, 0, i == 0, (i == 0) ? 2'b00 : 2'b10, 1, 0, 0, 3'(i), 0, 0);
  endfunction

  function automatic logic [12:0] v_mul_d(int i);
    return ev(1, 0, i == 0, (i == 0) ? 2'b01 : 2'b11, 0, 1, 1, 3'(i), 0, 0);
  endfunction

  function automatic logic [12:0] v_rem(int i);
    return ev(1, 0, 0, 2'b01, 0, 0, 0, 3'(i), 1, 1);
  endfunction

  function automatic logic [12:0] v_done();
    return ev(0, 1, 0, 2'b00, 0, 0, 0, 3'd0, 0, 0);
  endfunction

  task automatic push(input bit which, input logic [12:0] v);
    if (which) q1.push_back(v);
    else q3.push_back(v);
  endtask

  task automatic push_div(input int n, input bit which);
    for (int i = 0; i < n; i++) begin
      push(which, v_mul_n(i));
      if (i < n - 1) push(which, v_mul_d(i));
    end
    if (REM_EN) push(which, v_rem(n - 1));
    push(which, v_done());
  endtask

  task automatic step(input bit s);
    @(negedge clk);
    start = s;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input bit s);
    @(negedge clk);
    start1 = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #3;
    n_cmp++;
    if (obs3() !== 13'd0) begin
      n_err++;
      $display("FAIL reset_dut3: got %h expected %h", obs3(), 13'd0);
    end
    n_cmp++;
    if (obs1() !== 13'd0) begin
      n_err++;
      $display("FAIL reset_dut1: got %h expected %h", obs1(), 13'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (obs3() !== 13'd0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %h expected %h", obs3(), 13'd0);
    end
  endtask

  task automatic test_single_division();
    logic [12:0] exp;
    int cyc = 0, busy_cnt = 0, done_cyc = -1;
    bit first = 1'b1;
    push_div(3, 0);
    push(0, 13'd0);
    while (q3.size() > 0) begin
      step(first);
      first = 1'b0;
      cyc++;
      exp = q3.pop_front();
      n_cmp++;
      if (obs3() !== exp) begin
        n_err++;
        $display("FAIL single_cyc%0d: got %h expected %h", cyc, obs3(), exp);
      end
      if (busy) busy_cnt++;
      if (done && done_cyc < 0) done_cyc = cyc;
    end
    n_cmp++;
    if (busy_cnt !== (REM_EN ? 6 : 5)) begin
      n_err++;
      $display("FAIL busy_len: got %0d expected %0d", busy_cnt, REM_EN ? 6 : 5);
    end
    n_cmp++;
    if (done_cyc !== (REM_EN ? 7 : 6)) begin
      n_err++;
      $display("FAIL done_cycle: got %0d expected %0d", done_cyc, REM_EN ? 7 : 6);
    end
  endtask

  task automatic test_start_ignored();
    logic [12:0] exp;
    int len, idx = 0, n_done = 0;
    push_div(3, 0);
    len = q3.size();
    push(0, 13'd0);
    push(0, 13'd0);
    while (q3.size() > 0) begin
      step((idx == 0) || (idx >= 1 && idx <= len));
      exp = q3.pop_front();
      n_cmp++;
      if (obs3() !== exp) begin
        n_err++;
        $display("FAIL ignored_cyc%0d: got %h expected %h", idx, obs3(), exp);
      end
      if (done) n_done++;
      idx++;
    end
    n_cmp++;
    if (n_done !== 1) begin
      n_err++;
      $display("FAIL ignored_done_count: got %0d expected 1", n_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp;
    int idx = 0, n_done = 0;
    push_div(3, 0);
    push(0, 13'd0);
    push_div(3, 0);
    push(0, 13'd0);
    while (q3.size() > 0) begin
      step(1'b1);
      exp = q3.pop_front();
      n_cmp++;
      if (obs3() !== exp) begin
        n_err++;
        $display("FAIL held_cyc%0d: got %h expected %h", idx, obs3(), exp);
      end
      if (done) n_done++;
      idx++;
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (n_done !== 2) begin
      n_err++;
      $display("FAIL held_done_count: got %0d expected 2", n_done);
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] exp;
    int idx = 0;
    bit first = 1'b1;
    push(0, v_mul_n(0));
    push(0, v_mul_d(0));
    push(0, v_mul_n(1));
    push(0, v_mul_d(1));
    while (q3.size() > 0) begin
      step(first);
      first = 1'b0;
      exp = q3.pop_front();
      n_cmp++;
      if (obs3() !== exp) begin
        n_err++;
        $display("FAIL pre_reset_cyc%0d: got %h expected %h", idx, obs3(), exp);
      end
      idx++;
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (obs3() !== 13'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h expected %h", obs3(), 13'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    push_div(3, 0);
    push(0, 13'd0);
    first = 1'b1;
    idx = 0;
    while (q3.size() > 0) begin
      step(first);
      first = 1'b0;
      exp = q3.pop_front();
      n_cmp++;
      if (obs3() !== exp) begin
        n_err++;
        $display("FAIL post_reset_cyc%0d: got %h expected %h", idx, obs3(), exp);
      end
      idx++;
    end
  endtask

  task automatic test_iters1();
    logic [12:0] exp;
    int idx = 0;
    bit first = 1'b1, saw_d = 1'b0;
    push_div(1, 1);
    push(1, 13'd0);
    while (q1.size() > 0) begin
      step1(first);
      first = 1'b0;
      exp = q1.pop_front();
      n_cmp++;
      if (obs1() !== exp) begin
        n_err++;
        $display("FAIL iters1_cyc%0d: got %h expected %h", idx, obs1(), exp);
      end
      if (en_d1 || en_k1) saw_d = 1'b1;
      idx++;
    end
    n_cmp++;
    if (saw_d !== 1'b0) begin
      n_err++;
      $display("FAIL iters1_no_en_d: got %0b expected 0", saw_d);
    end
  endtask

  initial begin
    test_reset();
    test_single_division();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_iters1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gs_div_ctrl.md
GS_DIV_CTRL -- requirements
Module: gs_div_ctrl

Interface
REQ-001 The block SHALL have parameter ITERS, default 3, meaning the number of Goldschmidt N-multiplies per division (legal 1..7).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 The block SHALL have port busy  output  1  high from the first multiply state through the last compute state.
REQ-006 The block SHALL have port done  output  1  one-cycle pulse; quotient (and remainder, if enabled) are valid in the datapath registers.
REQ-007 The block SHALL have port mux_sel_k  output  1  k-operand select: 1 = table IA, 0 = kNext register.
REQ-008 The block SHALL have port mux_sel_op  output  2  right-operand select: 00 = N, 01 = D, 10 = nNext, 11 = dNext.
REQ-009 The block SHALL have port en_n  output  1  load nNext register from multOut[15:0].
REQ-010 The block SHALL have port en_d  output  1  load dNext register from multOut[15:0].
REQ-011 The block SHALL have port en_k  output  1  load kNext register from the two's-complement correction (2 - multOut).
REQ-012 The block SHALL have port iter  output  3  current iteration index, 0..ITERS-1.

Function
REQ-013 The block SHALL implement the states IDLE, MUL_N, MUL_D, REM (macro only), DONE.
REQ-014 In IDLE, start=1 SHALL move the block to MUL_N with iter=0; start=0 SHALL leave it in IDLE.
REQ-015 In MUL_N, outputs SHALL be en_n=1, mux_sel_op=00 with mux_sel_k=1 when iter=0, and mux_sel_op=10 with mux_sel_k=0 otherwise.
REQ-016 From MUL_N, the next state SHALL be MUL_D if iter<ITERS-1; otherwise REM (macro defined) or DONE.
REQ-017 In MUL_D, outputs SHALL be en_d=1 and en_k=1, with mux_sel_op=01 and mux_sel_k=1 when iter=0, and mux_sel_op=11 and mux_sel_k=0 otherwise.
REQ-018 Leaving MUL_D SHALL increment iter and return to MUL_N.
REQ-019 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-020 start SHALL be ignored in MUL_N, MUL_D, REM and DONE, with no queuing.
REQ-021 Busy duration SHALL be 2*ITERS-1 cycles (2*ITERS with the macro); done SHALL follow on the next cycle.
REQ-022 All outputs SHALL be Moore, decoded from the state and iter registers only.
REQ-023 In IDLE and DONE, all enables, mux_sel_k and mux_sel_op SHALL be 0, and at most one of en_n/en_d SHALL be high in any cycle.
REQ-024 iter SHALL hold 0 in IDLE and SHALL never exceed ITERS-1.
REQ-025 With ITERS=1, the sequence SHALL be MUL_N(iter=0) followed by DONE (or REM).

Reset
REQ-026 Asserting reset at any time, including mid-division, SHALL immediately force state=IDLE, iter=0, and busy=done=en_n=en_d=en_k=mux_sel_k=0, mux_sel_op=00.
REQ-027 After reset deasserts, the first start SHALL begin a complete fresh division, with no residual iteration state.

Configuration
REQ-028 Macro GS_DIV_REMAINDER_EN, when defined, SHALL add ports rem_mul (output, 1: multiplier k-operand = quotient) and en_rem (output, 1: load remainder = N - multOut), plus state REM.
REQ-029 In REM, outputs SHALL be rem_mul=1, mux_sel_op=00... no: mux_sel_op=01 (D), en_rem=1 and busy=1, followed by DONE; elsewhere rem_mul=en_rem=0.
REQ-030 Without GS_DIV_REMAINDER_EN, the ports rem_mul, en_rem and the REM state SHALL not exist, and MUL_N(last) SHALL go directly to DONE.

Verification
REQ-031 ITERS=3, no macro, start pulse in IDLE -> states MUL_N, MUL_D, MUL_N, MUL_D, MUL_N, DONE; busy high 5 cycles; done on cycle 6; iter sequence 0,0,1,1,2.
REQ-032 ITERS=3, no macro, check select encoding -> cycle1 sel_k=1/op=00/en_n; cycle2 sel_k=1/op=01/en_d+en_k; cycle3 sel_k=0/op=10; cycle4 sel_k=0/op=11.
REQ-033 start held high continuously -> new division begins only after the IDLE cycle following done; start pulses during busy produce no extra done.
REQ-034 reset asserted asynchronously in MUL_D with iter=1 -> outputs zero without waiting for a clock edge; next start yields the full 5-cycle sequence from iter=0.
REQ-035 GS_DIV_REMAINDER_EN defined, ITERS=2 -> MUL_N, MUL_D, MUL_N, REM (rem_mul=1, op=01, en_rem=1), DONE; busy high 4 cycles.
REQ-036 ITERS=1 -> single MUL_N (sel_k=1, op=00, en_n=1), then done pulse; en_d/en_k never asserted.
